// File: rtl/hs32_alu_sched.sv
// hs32_alu_sched: shares one combinational hs32_alu between two requesters.
// A round-robin arbiter feeds a one-deep issue stage that drives the ALU. The
// ALU output is captured into a one-deep result buffer with a valid/ready
// handshake. The block also owns the architectural NZCV flag register.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   i_valid0/1, o_ready0/1        per-port request handshake (ready is combinational)
//   i_op0/1, i_a0/1, i_b0/1       per-port ALU op and operands
//   i_setfl0/1                    per-port: result writes the flag register
//   o_res_valid, i_res_ready      result buffer handshake
//   o_res_id, o_res, o_res_fl     buffered requester id, result and op flags
//   o_flags                       architectural NZCV register
//   o_alu_a/b/op, o_alu_fl        to the shared ALU (issue-stage registers, flags)
//   i_alu_r, i_alu_fl             from the shared ALU
module hs32_alu_sched (
    input  logic        clk,
    input  logic        rstn,

    input  logic        i_valid0,
    output logic        o_ready0,
    input  logic [3:0]  i_op0,
    input  logic [31:0] i_a0,
    input  logic [31:0] i_b0,
    input  logic        i_setfl0,

    input  logic        i_valid1,
    output logic        o_ready1,
    input  logic [3:0]  i_op1,
    input  logic [31:0] i_a1,
    input  logic [31:0] i_b1,
    input  logic        i_setfl1,

    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic        o_res_id,
    output logic [31:0] o_res,
    output logic [3:0]  o_res_fl,
    output logic [3:0]  o_flags,

    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [3:0]  o_alu_op,
    output logic [3:0]  o_alu_fl,
    input  logic [31:0] i_alu_r,
    input  logic [3:0]  i_alu_fl
);

    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 4;
    localparam int unsigned FLW = 4;

    // Operation payload as held in the issue stage.
    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic           setfl;
        logic           id;
    } issue_t;

    issue_t         issue_q;
    issue_t         req_c;
    logic           issue_v;
    logic           res_v;
    logic           ptr;
    logic           win_c;
    logic           adv_c;
    logic           acc_c;
    logic           take_c;
    logic [FLW-1:0] flags_q;

    // Issue stage drains when the result buffer is empty or being emptied.
    assign adv_c  = issue_v & (~res_v | i_res_ready);
    assign acc_c  = ~issue_v | adv_c;
    assign take_c = acc_c & (i_valid0 | i_valid1);

    // Round-robin pick; the pointer only matters when both ports request.
    always_comb begin
        win_c = 1'b0;
        if (i_valid0 && i_valid1) begin
            win_c = ptr;
        end else if (i_valid1) begin
            win_c = 1'b1;
        end
    end

    // Winning port's payload.
    always_comb begin
        req_c = '0;
        if (win_c) begin
            req_c.op    = i_op1;
            req_c.a     = i_a1;
            req_c.b     = i_b1;
            req_c.setfl = i_setfl1;
            req_c.id    = 1'b1;
        end else begin
            req_c.op    = i_op0;
            req_c.a     = i_a0;
            req_c.b     = i_b0;
            req_c.setfl = i_setfl0;
            req_c.id    = 1'b0;
        end
    end

    assign o_ready0 = acc_c & ~win_c & i_valid0;
    assign o_ready1 = acc_c &  win_c & i_valid1;

    // Issue stage and arbitration pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_q <= '0;
            issue_v <= 1'b0;
            ptr     <= 1'b0;
        end else if (take_c) begin
            issue_q <= req_c;
            issue_v <= 1'b1;
            ptr     <= ~win_c;
        end else if (adv_c) begin
            issue_v <= 1'b0;
        end
    end

    // Result buffer and architectural flags. A flag update lands on the same
    // edge the next op is issued, so that op already computes on new flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_v    <= 1'b0;
            o_res    <= '0;
            o_res_fl <= '0;
            o_res_id <= 1'b0;
            flags_q  <= '0;
        end else if (adv_c) begin
            res_v    <= 1'b1;
            o_res    <= i_alu_r;
            o_res_fl <= i_alu_fl;
            o_res_id <= issue_q.id;
            if (issue_q.setfl) begin
                flags_q <= i_alu_fl;
            end
        end else if (i_res_ready) begin
            res_v <= 1'b0;
        end
    end

    assign o_res_valid = res_v;
    assign o_flags     = flags_q;
    assign o_alu_a     = issue_q.a;
    assign o_alu_b     = issue_q.b;
    assign o_alu_op    = issue_q.op;
    assign o_alu_fl    = flags_q;

endmodule
